// File: rtl/game_pkg.sv
// Shared game definitions: health widths, round states, player indices and
// the saturating damage helper used by each health channel.
package game_pkg;

  localparam int HEALTH_W = 5;
  localparam logic [HEALTH_W-1:0] MAX_HEALTH = 5'd31;

  localparam int P1 = 0;
  localparam int P2 = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIGHT    = 2'd1,
    KO_DRAIN = 2'd2,
    OVER     = 2'd3
  } round_state_t;

  // Health minus damage, clamped at zero; the extra bit catches the borrow.
  function automatic logic [HEALTH_W-1:0] sat_sub(
    input logic [HEALTH_W-1:0] health,
    input logic [HEALTH_W-1:0] dmg
  );
    logic [HEALTH_W:0] diff;
    diff = {1'b0, health} - {1'b0, dmg};
    return diff[HEALTH_W] ? '0 : diff[HEALTH_W-1:0];
  endfunction

endpackage

// File: rtl/health_controller_if.sv
// Hit request bus between the two attack/hitbox units and the health
// controller. Bit 0 is P1 striking P2, bit 1 is P2 striking P1.
interface health_controller_if;

  logic [1:0]                    hit_valid;
  logic [game_pkg::HEALTH_W-1:0] hit_dmg_p1;
  logic [game_pkg::HEALTH_W-1:0] hit_dmg_p2;
  logic [1:0]                    hit_ready;

  modport master (
    output hit_valid,
    output hit_dmg_p1,
    output hit_dmg_p2,
    input  hit_ready
  );

  modport slave (
    input  hit_valid,
    input  hit_dmg_p1,
    input  hit_dmg_p2,
    output hit_ready
  );

endinterface

// File: rtl/health_channel.sv
// One player's health state: true health, drained display health,
// invulnerability window and sticky KO flag.
module health_channel
  import game_pkg::*;
#(
  parameter int IFRAME_CYCLES = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                refill,
  input  logic                apply,
  input  logic [HEALTH_W-1:0] dmg,
  input  logic                tick,
  output logic [HEALTH_W-1:0] curr_health,
  output logic [HEALTH_W-1:0] disp_health,
  output logic                invuln,
  output logic                ko,
  output logic                ko_event
);

  localparam int IFRAME_W = (IFRAME_CYCLES > 1) ? $clog2(IFRAME_CYCLES) : 1;

  logic [IFRAME_W-1:0] iframe_cnt;
  logic [HEALTH_W-1:0] new_health;
  logic                hit_effective;

  // A hit only lands when it carries damage and the player is not protected.
  always_comb begin
    hit_effective = apply && (dmg != '0) && !invuln;
    new_health    = sat_sub(curr_health, dmg);
    ko_event      = hit_effective && (new_health == '0);
  end

  // True health, KO flag and invulnerability countdown.
  always_ff @(posedge clk) begin
    if (!rst_n || refill) begin
      curr_health <= MAX_HEALTH;
      ko          <= 1'b0;
      invuln      <= 1'b0;
      iframe_cnt  <= '0;
    end else if (hit_effective) begin
      curr_health <= new_health;
      invuln      <= 1'b1;
      iframe_cnt  <= IFRAME_W'(IFRAME_CYCLES - 1);
      if (new_health == '0) begin
        ko <= 1'b1;
      end
    end else if (invuln) begin
      if (iframe_cnt == '0) begin
        invuln <= 1'b0;
      end else begin
        iframe_cnt <= iframe_cnt - IFRAME_W'(1);
      end
    end
  end

  // Display health snaps up to true health and drains down one step per tick.
  always_ff @(posedge clk) begin
    if (!rst_n || refill) begin
      disp_health <= MAX_HEALTH;
    end else if (curr_health > disp_health) begin
      disp_health <= curr_health;
    end else if (tick && (disp_health > curr_health)) begin
      disp_health <= disp_health - HEALTH_W'(1);
    end
  end

endmodule

// File: rtl/health_controller.sv
// Health controller top: hit arbitration, drain pacing and the round FSM
// around two health channels.
module health_controller
  import game_pkg::*;
#(
  parameter int DRAIN_DIV     = 2500000,
  parameter int IFRAME_CYCLES = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                round_start,
  health_controller_if.slave  hit_bus,
  output logic [HEALTH_W-1:0] curr_health_p1,
  output logic [HEALTH_W-1:0] curr_health_p2,
  output logic [HEALTH_W-1:0] disp_health_p1,
  output logic [HEALTH_W-1:0] disp_health_p2,
  output logic [1:0]          invuln,
  output logic [1:0]          ko,
  output logic                round_over
);

  localparam int DRAIN_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  round_state_t       state;
  logic               rr_ptr;
  logic [1:0]         grant;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_tick;
  logic               apply_p1;
  logic               apply_p2;
  logic               ko_event_p1;
  logic               ko_event_p2;

  // Grant at most one hit in FIGHT; after the round is decided every hit is
  // accepted so the attackers never stall, and simply thrown away.
  always_comb begin
    grant             = 2'b00;
    hit_bus.hit_ready = 2'b00;
    case (state)
      FIGHT: begin
        if (hit_bus.hit_valid == 2'b11) begin
          grant = rr_ptr ? 2'b10 : 2'b01;
        end else begin
          grant = hit_bus.hit_valid;
        end
        hit_bus.hit_ready = grant;
      end
      KO_DRAIN, OVER: hit_bus.hit_ready = 2'b11;
      default: ;
    endcase
  end

  assign apply_p2   = grant[P1] && !round_start;
  assign apply_p1   = grant[P2] && !round_start;
  assign drain_tick = (state != IDLE) && (drain_cnt == DRAIN_W'(DRAIN_DIV - 1));

  // Round-robin pointer moves to the requester that did not just win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant != 2'b00) begin
      rr_ptr <= grant[P1];
    end
  end

  // Free-running drain divider, parked in IDLE and restarted each round.
  always_ff @(posedge clk) begin
    if (!rst_n || round_start || (state == IDLE)) begin
      drain_cnt <= '0;
    end else if (drain_tick) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  // Round state machine; round_start from anywhere refills and restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      round_over <= 1'b0;
    end else if (round_start) begin
      state      <= FIGHT;
      round_over <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        FIGHT: begin
          if (ko_event_p1 || ko_event_p2) begin
            state <= KO_DRAIN;
          end
        end
        KO_DRAIN: begin
          if ((ko[P1] && (disp_health_p1 == '0)) ||
              (ko[P2] && (disp_health_p2 == '0))) begin
            state      <= OVER;
            round_over <= 1'b1;
          end
        end
        OVER: ;
        default: begin
          state      <= IDLE;
          round_over <= 1'b0;
        end
      endcase
    end
  end

  health_channel #(
    .IFRAME_CYCLES (IFRAME_CYCLES)
  ) u_p1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .refill      (round_start),
    .apply       (apply_p1),
    .dmg         (hit_bus.hit_dmg_p2),
    .tick        (drain_tick),
    .curr_health (curr_health_p1),
    .disp_health (disp_health_p1),
    .invuln      (invuln[P1]),
    .ko          (ko[P1]),
    .ko_event    (ko_event_p1)
  );

  health_channel #(
    .IFRAME_CYCLES (IFRAME_CYCLES)
  ) u_p2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .refill      (round_start),
    .apply       (apply_p2),
    .dmg         (hit_bus.hit_dmg_p1),
    .tick        (drain_tick),
    .curr_health (curr_health_p2),
    .disp_health (disp_health_p2),
    .invuln      (invuln[P2]),
    .ko          (ko[P2]),
    .ko_event    (ko_event_p2)
  );

endmodule

// File: tb/tb_health_controller.sv
// Directed bench for health_controller with short drain and iframe periods.
module tb_health_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       round_start = 1'b0;
  logic [4:0] curr_health_p1;
  logic [4:0] curr_health_p2;
  logic [4:0] disp_health_p1;
  logic [4:0] disp_health_p2;
  logic [1:0] invuln;
  logic [1:0] ko;
  logic       round_over;

  int checks = 0;
  int errors = 0;

  health_controller_if bus ();

  health_controller #(
    .DRAIN_DIV     (4),
    .IFRAME_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .round_start    (round_start),
    .hit_bus        (bus),
    .curr_health_p1 (curr_health_p1),
    .curr_health_p2 (curr_health_p2),
    .disp_health_p1 (disp_health_p1),
    .disp_health_p2 (disp_health_p2),
    .invuln         (invuln),
    .ko             (ko),
    .round_over     (round_over)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rs, input logic [1:0] valid,
                               input logic [4:0] d1, input logic [4:0] d2);
    round_start    = rs;
    bus.hit_valid  = valid;
    bus.hit_dmg_p1 = d1;
    bus.hit_dmg_p2 = d2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    bit seen;

    // Reset and idle behaviour
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    repeat (2) stepCycle();
    rst_n = 1'b1;
    checkOutput("rst_curr_p1", 32'(curr_health_p1), 31);
    checkOutput("rst_disp_p2", 32'(disp_health_p2), 31);
    checkOutput("rst_ko", 32'(ko), 0);
    checkOutput("rst_round_over", 32'(round_over), 0);
    applyStimulus(1'b0, 2'b01, 5'd5, 5'd0);
    #1;
    checkOutput("idle_ready", 32'(bus.hit_ready), 0);

    // Round start, then a single 5-point hit on P2 (edge R)
    applyStimulus(1'b1, 2'b00, 5'd0, 5'd0);
    stepCycle();
    applyStimulus(1'b0, 2'b01, 5'd5, 5'd0);
    checkOutput("fight_full_p2", 32'(curr_health_p2), 31);
    #1;
    checkOutput("single_ready", 32'(bus.hit_ready), 1);
    stepCycle();                                     // R+1
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("single_curr_p2", 32'(curr_health_p2), 26);
    checkOutput("single_curr_p1", 32'(curr_health_p1), 31);
    checkOutput("single_invuln", 32'(invuln), 2);
    checkOutput("single_disp_hold", 32'(disp_health_p2), 31);
    repeat (2) stepCycle();                          // R+3
    checkOutput("drain_before_tick", 32'(disp_health_p2), 31);
    stepCycle();                                     // R+4
    checkOutput("drain_tick1", 32'(disp_health_p2), 30);
    repeat (4) stepCycle();                          // R+8
    checkOutput("drain_tick2", 32'(disp_health_p2), 29);
    checkOutput("iframe_last", 32'(invuln), 2);
    stepCycle();                                     // R+9
    checkOutput("iframe_expired", 32'(invuln), 0);
    repeat (10) stepCycle();                         // R+19
    checkOutput("drain_tick4", 32'(disp_health_p2), 27);
    stepCycle();                                     // R+20
    checkOutput("drain_tick5", 32'(disp_health_p2), 26);
    repeat (4) stepCycle();                          // R+24
    checkOutput("drain_floor", 32'(disp_health_p2), 26);

    // Fresh reset so the pointer starts at P1, then simultaneous hits (edge S)
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'b00, 5'd0, 5'd0);
    stepCycle();
    applyStimulus(1'b0, 2'b11, 5'd3, 5'd3);
    #1;
    checkOutput("both_ready_first", 32'(bus.hit_ready), 1);
    stepCycle();                                     // S+1
    checkOutput("both_curr_p2", 32'(curr_health_p2), 28);
    checkOutput("both_curr_p1_wait", 32'(curr_health_p1), 31);
    checkOutput("both_ready_second", 32'(bus.hit_ready), 2);
    stepCycle();                                     // S+2
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("both_curr_p1", 32'(curr_health_p1), 28);
    checkOutput("both_invuln", 32'(invuln), 3);

    // Hit into P2's iframes is accepted and dropped
    stepCycle();                                     // S+3
    applyStimulus(1'b0, 2'b01, 5'd4, 5'd0);
    #1;
    checkOutput("drop_ready", 32'(bus.hit_ready), 1);
    stepCycle();                                     // S+4
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("drop_curr_p2", 32'(curr_health_p2), 28);
    repeat (5) stepCycle();                          // S+9
    checkOutput("iframe_p2_done", 32'(invuln), 1);
    applyStimulus(1'b0, 2'b01, 5'd4, 5'd0);
    stepCycle();                                     // S+10
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("late_hit_curr_p2", 32'(curr_health_p2), 24);
    checkOutput("late_hit_invuln", 32'(invuln), 2);

    // Bring P2 down to 2, then saturate to 0
    repeat (8) stepCycle();                          // S+18
    applyStimulus(1'b0, 2'b01, 5'd22, 5'd0);
    stepCycle();                                     // S+19
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("low_curr_p2", 32'(curr_health_p2), 2);
    repeat (8) stepCycle();                          // S+27
    applyStimulus(1'b0, 2'b01, 5'd7, 5'd0);
    stepCycle();                                     // S+28
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("sat_curr_p2", 32'(curr_health_p2), 0);
    checkOutput("ko_p2", 32'(ko), 2);
    #1;
    checkOutput("ko_drain_ready", 32'(bus.hit_ready), 3);
    checkOutput("ko_drain_not_over", 32'(round_over), 0);
    applyStimulus(1'b0, 2'b10, 5'd0, 5'd5);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("ko_drain_hit_dropped", 32'(curr_health_p1), 28);

    // Wait for the display to drain out and the round to end
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      stepCycle();
      if (round_over) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("round_over_seen", 32'(seen), 1);
    checkOutput("over_disp_p2", 32'(disp_health_p2), 0);
    checkOutput("over_disp_p1", 32'(disp_health_p1), 28);
    checkOutput("over_ko_sticky", 32'(ko), 2);

    // round_start in OVER beats a same-cycle hit (edge O)
    applyStimulus(1'b1, 2'b01, 5'd5, 5'd0);
    #1;
    checkOutput("over_ready", 32'(bus.hit_ready), 3);
    stepCycle();                                     // O
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("restart_curr_p2", 32'(curr_health_p2), 31);
    checkOutput("restart_disp_p2", 32'(disp_health_p2), 31);
    checkOutput("restart_ko", 32'(ko), 0);
    checkOutput("restart_round_over", 32'(round_over), 0);
    checkOutput("restart_invuln", 32'(invuln), 0);
    stepCycle();                                     // O+1
    checkOutput("restart_hit_ignored", 32'(curr_health_p2), 31);

    // Reset in the middle of a drain
    applyStimulus(1'b0, 2'b01, 5'd10, 5'd0);
    stepCycle();                                     // O+2
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    checkOutput("mid_curr_p2", 32'(curr_health_p2), 21);
    repeat (5) stepCycle();                          // O+7
    checkOutput("mid_disp_p2", 32'(disp_health_p2), 30);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("mid_rst_curr_p2", 32'(curr_health_p2), 31);
    checkOutput("mid_rst_disp_p2", 32'(disp_health_p2), 31);
    checkOutput("mid_rst_invuln", 32'(invuln), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b01, 5'd3, 5'd0);
    #1;
    checkOutput("mid_rst_idle_ready", 32'(bus.hit_ready), 0);
    applyStimulus(1'b1, 2'b00, 5'd0, 5'd0);
    stepCycle();
    applyStimulus(1'b0, 2'b11, 5'd3, 5'd3);
    #1;
    checkOutput("mid_rst_pointer", 32'(bus.hit_ready), 1);
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0);
    stepCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
